// File: rtl/chacha_pkg.sv
// Shared types and constants for the sequential ChaCha block engine.
// The step table maps each quarter-round slot to its four state-word indices.
package chacha_pkg;

    localparam int NUM_WORDS = 16;

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        ROUND = 2'd1,
        OUT   = 2'd2
    } state_t;

    // Packed tables: the rightmost entry is slot 0; slots 0..3 are columns, 4..7 are diagonals.
    localparam logic [7:0][3:0] A_IDX = {4'd3, 4'd2, 4'd1, 4'd0, 4'd3, 4'd2, 4'd1, 4'd0};
    localparam logic [7:0][3:0] B_IDX = {4'd4, 4'd7, 4'd6, 4'd5, 4'd7, 4'd6, 4'd5, 4'd4};
    localparam logic [7:0][3:0] C_IDX = {4'd9, 4'd8, 4'd11, 4'd10, 4'd11, 4'd10, 4'd9, 4'd8};
    localparam logic [7:0][3:0] D_IDX = {4'd14, 4'd13, 4'd12, 4'd15, 4'd15, 4'd14, 4'd13, 4'd12};

    localparam logic [31:0] SIGMA0 = 32'h61707865;
    localparam logic [31:0] SIGMA1 = 32'h3320646e;
    localparam logic [31:0] SIGMA2 = 32'h79622d32;
    localparam logic [31:0] SIGMA3 = 32'h6b206574;

    function automatic logic [31:0] rotl32(input logic [31:0] x, input int unsigned n);
        return (x << n) | (x >> (32 - n));
    endfunction

endpackage

// File: rtl/chacha_qr.sv
// Combinational ChaCha quarter-round: four add/xor/rotate stages on (a,b,c,d).
module chacha_qr
    import chacha_pkg::*;
(
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic [31:0] c_i,
    input  logic [31:0] d_i,
    output logic [31:0] a_o,
    output logic [31:0] b_o,
    output logic [31:0] c_o,
    output logic [31:0] d_o
);

    logic [31:0] a1, b1, c1, d1;

    always_comb begin
        a1  = a_i + b_i;
        d1  = rotl32(d_i ^ a1, 16);
        c1  = c_i + d1;
        b1  = rotl32(b_i ^ c1, 12);
        a_o = a1 + b1;
        d_o = rotl32(d1 ^ a_o, 8);
        c_o = c1 + d_o;
        b_o = rotl32(b1 ^ c_o, 7);
    end

endmodule

// File: rtl/chacha_block_seq.sv
// Sequential ChaCha block function: serial load, one quarter-round per cycle,
// feed-forward add of the original state, serial ready/valid output.
module chacha_block_seq
    import chacha_pkg::*;
#(
    parameter int DOUBLE_ROUNDS = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic        busy
);

    localparam logic [3:0] DR_LAST = 4'(DOUBLE_ROUNDS - 1);

    state_t      state_q, state_d;
    logic [3:0]  word_idx_q, word_idx_d;
    logic [2:0]  qr_idx_q, qr_idx_d;
    logic [3:0]  dr_cnt_q, dr_cnt_d;
    logic [31:0] orig_q [NUM_WORDS];
    logic [31:0] orig_d [NUM_WORDS];
    logic [31:0] work_q [NUM_WORDS];
    logic [31:0] work_d [NUM_WORDS];

    logic [3:0]  a_idx, b_idx, c_idx, d_idx;
    logic [31:0] qa, qb, qc, qd;

    assign a_idx = A_IDX[qr_idx_q];
    assign b_idx = B_IDX[qr_idx_q];
    assign c_idx = C_IDX[qr_idx_q];
    assign d_idx = D_IDX[qr_idx_q];

    chacha_qr u_qr (
        .a_i (work_q[a_idx]),
        .b_i (work_q[b_idx]),
        .c_i (work_q[c_idx]),
        .d_i (work_q[d_idx]),
        .a_o (qa),
        .b_o (qb),
        .c_o (qc),
        .d_o (qd)
    );

    always_comb begin
        state_d    = state_q;
        word_idx_d = word_idx_q;
        qr_idx_d   = qr_idx_q;
        dr_cnt_d   = dr_cnt_q;
        orig_d     = orig_q;
        work_d     = work_q;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        out_data   = '0;
        busy       = 1'b0;
        unique case (state_q)
            LOAD: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    orig_d[word_idx_q] = in_data;
                    work_d[word_idx_q] = in_data;
                    word_idx_d         = word_idx_q + 4'd1;
                    if (word_idx_q == 4'd15) state_d = ROUND;
                end
            end
            ROUND: begin
                busy          = 1'b1;
                work_d[a_idx] = qa;
                work_d[b_idx] = qb;
                work_d[c_idx] = qc;
                work_d[d_idx] = qd;
                qr_idx_d      = qr_idx_q + 3'd1;
                if (qr_idx_q == 3'd7) begin
                    if (dr_cnt_q == DR_LAST) begin
                        dr_cnt_d = '0;
                        state_d  = OUT;
                    end else begin
                        dr_cnt_d = dr_cnt_q + 4'd1;
                    end
                end
            end
            OUT: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                out_data  = work_q[word_idx_q] + orig_q[word_idx_q];
                if (out_ready) begin
                    word_idx_d = word_idx_q + 4'd1;
                    if (word_idx_q == 4'd15) state_d = LOAD;
                end
            end
            default: state_d = LOAD;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= LOAD;
            word_idx_q <= '0;
            qr_idx_q   <= '0;
            dr_cnt_q   <= '0;
        end else begin
            state_q    <= state_d;
            word_idx_q <= word_idx_d;
            qr_idx_q   <= qr_idx_d;
            dr_cnt_q   <= dr_cnt_d;
        end
    end

    // Word storage carries no reset; a discarded block is simply overwritten by the next load.
    always_ff @(posedge clk) begin
        orig_q <= orig_d;
        work_q <= work_d;
    end

endmodule

// File: tb/tb_chacha_block_seq.sv
// Scoreboarded bench for chacha_block_seq: ChaCha20 and ChaCha8 instances
// checked against a reference block function and the RFC 8439 vector.
module tb_chacha_block_seq;
    import chacha_pkg::*;

    typedef logic [31:0] blk_t [16];

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] in_data = '0;
    logic        sel = 1'b0;

    logic        ir20, ov20, busy20, ir8, ov8, busy8;
    logic [31:0] od20, od8;
    logic        in_ready, out_valid, busy;
    logic [31:0] out_data;

    int          tests = 0;
    int          failed = 0;
    logic [31:0] exp_q [$];

    always #5 clk = ~clk;

    chacha_block_seq #(.DOUBLE_ROUNDS(10)) dut20 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid & ~sel), .in_ready(ir20), .in_data(in_data),
        .out_valid(ov20), .out_ready(out_ready & ~sel), .out_data(od20),
        .busy(busy20)
    );

    chacha_block_seq #(.DOUBLE_ROUNDS(4)) dut8 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid & sel), .in_ready(ir8), .in_data(in_data),
        .out_valid(ov8), .out_ready(out_ready & sel), .out_data(od8),
        .busy(busy8)
    );

    assign in_ready  = sel ? ir8   : ir20;
    assign out_valid = sel ? ov8   : ov20;
    assign out_data  = sel ? od8   : od20;
    assign busy      = sel ? busy8 : busy20;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        tests++;
        assert (obs === exp_v) else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    function automatic logic [31:0] rl(input logic [31:0] x, input int n);
        return (x << n) | (x >> (32 - n));
    endfunction

    task automatic chacha_ref(input blk_t s, input int dr, output blk_t o);
        blk_t x;
        int idx [8][4];
        logic [31:0] a, b, c, d;
        idx = '{'{0,4,8,12}, '{1,5,9,13}, '{2,6,10,14}, '{3,7,11,15},
                '{0,5,10,15}, '{1,6,11,12}, '{2,7,8,13}, '{3,4,9,14}};
        x = s;
        for (int r = 0; r < dr; r++) begin
            for (int q = 0; q < 8; q++) begin
                a = x[idx[q][0]]; b = x[idx[q][1]]; c = x[idx[q][2]]; d = x[idx[q][3]];
                a = a + b; d = rl(d ^ a, 16);
                c = c + d; b = rl(b ^ c, 12);
                a = a + b; d = rl(d ^ a, 8);
                c = c + d; b = rl(b ^ c, 7);
                x[idx[q][0]] = a; x[idx[q][1]] = b; x[idx[q][2]] = c; x[idx[q][3]] = d;
            end
        end
        for (int i = 0; i < 16; i++) o[i] = x[i] + s[i];
    endtask

    task automatic push_blk(input blk_t e);
        for (int i = 0; i < 16; i++) exp_q.push_back(e[i]);
    endtask

    task automatic feed(input blk_t w, input bit gaps);
        int g;
        int guard;
        for (int i = 0; i < 16; i++) begin
            if (gaps) begin
                g = $urandom_range(0, 2);
                repeat (g) begin
                    @(negedge clk);
                    in_valid = 1'b0;
                end
            end
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = w[i];
            guard = 0;
            while (!in_ready && guard < 50) begin
                @(negedge clk);
                guard++;
            end
            if (guard >= 50) chk("load_timeout", 32'(guard), 32'd0);
        end
    endtask

    // Called right after feed: the first negedge reached here follows the edge accepting word 15.
    task automatic drain(input bit rnd, input int lat, input int exp_busy);
        int j;
        int busy_n;
        int n;
        int guard;
        bit held;
        logic [31:0] held_d;
        logic [31:0] e;
        j = -1;
        busy_n = 0;
        do begin
            @(negedge clk);
            j++;
            in_valid  = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
            out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
            if (busy) busy_n++;
            if (!out_valid) chk("in_ready_round", 32'(in_ready), 32'd0);
        end while (!out_valid && j < 400);
        chk("first_valid_latency", 32'(j), 32'(lat));
        n = 0;
        guard = 0;
        held = 1'b0;
        held_d = '0;
        while (n < 16 && guard < 2000) begin
            chk("in_ready_out", 32'(in_ready), 32'd0);
            if (held) chk("out_hold", out_data, held_d);
            out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (rnd) in_valid = 1'($urandom_range(0, 1));
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("scoreboard_empty", out_data, 32'hxxxxxxxx);
                end else begin
                    e = exp_q.pop_front();
                    chk($sformatf("out_word%0d", n), out_data, e);
                end
                n++;
                held = 1'b0;
            end else if (out_valid) begin
                held = 1'b1;
                held_d = out_data;
            end
            if (n < 16) begin
                @(negedge clk);
                guard++;
                if (busy) busy_n++;
            end
        end
        if (guard >= 2000) chk("drain_timeout", 32'(n), 32'd16);
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b0;
        chk("in_ready_after", 32'(in_ready), 32'd1);
        chk("out_valid_after", 32'(out_valid), 32'd0);
        chk("busy_after", 32'(busy), 32'd0);
        if (exp_busy >= 0) chk("busy_cycles", 32'(busy_n), 32'(exp_busy));
    endtask

    initial begin
        blk_t v1, v1b, vz, rfc, ref_o;

        v1 = '{SIGMA0, SIGMA1, SIGMA2, SIGMA3,
               32'h03020100, 32'h07060504, 32'h0b0a0908, 32'h0f0e0d0c,
               32'h13121110, 32'h17161514, 32'h1b1a1918, 32'h1f1e1d1c,
               32'h00000001, 32'h09000000, 32'h4a000000, 32'h00000000};
        rfc = '{32'he4e7f110, 32'h15593bd1, 32'h1fdd0f50, 32'hc47120a3,
                32'hc7f4d1c7, 32'h0368c033, 32'h9aaa2204, 32'h4e6cd4c3,
                32'h466482d2, 32'h09aa9f07, 32'h05d7c214, 32'ha2028bd9,
                32'hd19c12b5, 32'hb94e16de, 32'he883d0cb, 32'h4e3c50a2};
        for (int i = 0; i < 16; i++) vz[i] = '0;
        v1b = v1;
        v1b[12] = 32'h00000002;

        // Reset state
        @(negedge clk);
        chk("rst_in_ready", 32'(ir20), 32'd1);
        chk("rst_out_valid", 32'(ov20), 32'd0);
        chk("rst_busy", 32'(busy20), 32'd0);
        chk("rst_out_data", od20, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_in_ready", 32'(in_ready), 32'd1);

        // 1: RFC vector, ready held high
        push_blk(rfc);
        feed(v1, 1'b0);
        drain(1'b0, 80, 96);

        // 2: all-zero state
        push_blk(vz);
        feed(vz, 1'b0);
        drain(1'b0, 80, 96);

        // 3: RFC vector with input gaps and random backpressure
        push_blk(rfc);
        feed(v1, 1'b1);
        drain(1'b1, 80, -1);

        // 4: reset in the middle of the round phase
        feed(v1, 1'b0);
        repeat (38) @(negedge clk);
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        chk("midrst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        push_blk(rfc);
        feed(v1, 1'b0);
        drain(1'b0, 80, 96);

        // 5: back-to-back blocks, second with block counter 2
        chacha_ref(v1, 10, ref_o);
        push_blk(ref_o);
        feed(v1, 1'b0);
        drain(1'b0, 80, 96);
        chacha_ref(v1b, 10, ref_o);
        push_blk(ref_o);
        feed(v1b, 1'b0);
        drain(1'b0, 80, 96);

        // 6: ChaCha8 instance
        sel = 1'b1;
        @(negedge clk);
        chacha_ref(v1, 4, ref_o);
        push_blk(ref_o);
        feed(v1, 1'b0);
        drain(1'b0, 32, 48);

        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule
